// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for the instruction/data memory-port arbiter.
//   owner_e    : which requester owns an access (instruction fetch or LSU)
//   state_e    : arbiter FSM state
//   dbg_t      : internal state exported for observation
//   WAIT_CNT_W : width of the wait-state counter (supports 0..15 wait states)
package mem_arbiter_pkg;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  typedef enum logic {
    ST_IDLE = 1'b0,  // grants allowed
    ST_WAIT = 1'b1   // memory busy, no grants
  } state_e;

  localparam int WAIT_CNT_W = 4;

  typedef struct packed {
    state_e                  state;
    owner_e                  last_owner;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
  } dbg_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the instruction port, the data (LSU) port and the
// shared memory port seen by mem_arbiter.
//   slave  : arbiter view (takes requests and mem_rdata_i, drives gnt/rvalid/rdata/mem_*)
//   master : environment view (core + memory side), the mirror image
//
// Handshake: a requester raises req with stable fields and holds them until
// the cycle in which gnt is high; that cycle is the transfer. Exactly one
// cycle of rvalid follows each grant, after the memory wait states.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 24
);
  logic                  instr_req_i;
  logic [ADDR_WIDTH-1:0] instr_addr_i;
  logic                  instr_gnt_o;
  logic                  instr_rvalid_o;
  logic [31:0]           instr_rdata_o;

  logic                  data_req_i;
  logic [ADDR_WIDTH-1:0] data_addr_i;
  logic                  data_we_i;
  logic [3:0]            data_be_i;
  logic [31:0]           data_wdata_i;
  logic                  data_gnt_o;
  logic                  data_rvalid_o;
  logic [31:0]           data_rdata_o;

  logic                  mem_en_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_we_o;
  logic [3:0]            mem_be_o;
  logic [31:0]           mem_wdata_o;
  logic [31:0]           mem_rdata_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o,
    output mem_en_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o,
    input  mem_en_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin pick with its last-owner flop.
//   en         : grants allowed this cycle
//   req_instr  : instruction requester active
//   req_data   : data requester active
//   gnt_instr  : instruction requester wins (combinational)
//   gnt_data   : data requester wins (combinational)
//   last_owner : owner of the most recent grant; resets to OWNER_INSTR so
//                the data side wins the first tie
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  logic   req_instr,
  input  logic   req_data,
  output logic   gnt_instr,
  output logic   gnt_data,
  output owner_e last_owner
);

  always_comb begin
    gnt_instr = 1'b0;
    gnt_data  = 1'b0;
    if (en) begin
      if (req_instr && req_data) begin
        // Tie: whoever did not win last time goes now.
        if (last_owner == OWNER_INSTR) gnt_data  = 1'b1;
        else                           gnt_instr = 1'b1;
      end else begin
        gnt_instr = req_instr;
        gnt_data  = req_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         last_owner <= OWNER_INSTR;
    else if (gnt_data)  last_owner <= OWNER_DATA;
    else if (gnt_instr) last_owner <= OWNER_INSTR;
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM port between the
// instruction-fetch and LSU ports with round-robin arbitration and a fixed
// number of memory wait states after each access.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : instruction port, data port and memory port (slave view)
//   dbg        : FSM state, last owner and wait counter
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 24,
  parameter int WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_arbiter_if.slave    bus,
  output dbg_t            dbg
);

  state_e                state, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_d;
  logic                  resp_pend;
  owner_e                resp_owner;
  owner_e                last_owner;
  logic                  gnt_instr, gnt_data, grant, resp_fire, arb_en;
  logic [ADDR_WIDTH-1:0] mem_addr;

  // Grants are suppressed while reset is asserted, not just after it.
  assign arb_en = rst_n && (state == ST_IDLE);
  assign grant  = gnt_instr || gnt_data;

  rr_arb2 u_rr_arb2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (arb_en),
    .req_instr  (bus.instr_req_i),
    .req_data   (bus.data_req_i),
    .gnt_instr  (gnt_instr),
    .gnt_data   (gnt_data),
    .last_owner (last_owner)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_cnt_d;
    end
  end

  // FSM next state: with wait_cnt loaded to N the FSM spends N cycles in
  // ST_WAIT, so the next grant slot is 1+N cycles after the previous one.
  always_comb begin
    state_d    = state;
    wait_cnt_d = wait_cnt;
    unique case (state)
      ST_IDLE: begin
        if (grant && (WAIT_STATES > 0)) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WAIT_CNT_W'(WAIT_STATES);
        end
      end
      ST_WAIT: begin
        if (wait_cnt <= 1) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response tracking: the response for a grant fires in the first ST_IDLE
  // cycle after it. A new grant in that same cycle re-arms the tracker.
  assign resp_fire = resp_pend && (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_pend  <= 1'b0;
      resp_owner <= OWNER_INSTR;
    end else if (grant) begin
      resp_pend  <= 1'b1;
      resp_owner <= gnt_data ? OWNER_DATA : OWNER_INSTR;
    end else if (resp_fire) begin
      resp_pend  <= 1'b0;
    end
  end

  assign bus.instr_gnt_o    = gnt_instr;
  assign bus.data_gnt_o     = gnt_data;
  assign bus.instr_rvalid_o = resp_fire && (resp_owner == OWNER_INSTR);
  assign bus.data_rvalid_o  = resp_fire && (resp_owner == OWNER_DATA);
  assign bus.instr_rdata_o  = bus.mem_rdata_i;
  assign bus.data_rdata_o   = bus.mem_rdata_i;

  // Memory port mux: data fields by default, instruction fields (as a
  // full-word read) only when the fetch wins.
  always_comb begin
    bus.mem_en_o    = grant;
    mem_addr        = bus.data_addr_i;
    bus.mem_we_o    = bus.data_we_i && rst_n;
    bus.mem_be_o    = bus.data_be_i;
    bus.mem_wdata_o = bus.data_wdata_i;
    if (gnt_instr) begin
      mem_addr        = bus.instr_addr_i;
      bus.mem_we_o    = 1'b0;
      bus.mem_be_o    = 4'b1111;
      bus.mem_wdata_o = '0;
    end
  end

  assign bus.mem_addr_o = mem_addr;

  always_comb begin
    dbg            = '0;
    dbg.state      = state;
    dbg.last_owner = last_owner;
    dbg.wait_cnt   = wait_cnt;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with three instances
// (WAIT_STATES = 0, 2, 3), each with a small behavioural RAM behind it.
// Inputs change at the falling edge; outputs are checked 1 ns later.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = 24;

  logic clk = 1'b0;
  logic rst_n0, rst_n2, rst_n3;
  dbg_t dbg0, dbg2, dbg3;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [31:0] mem0 [256];
  logic [31:0] mem2 [256];
  logic [31:0] mem3 [256];

  mem_arbiter_if #(.ADDR_WIDTH(AW)) bus0 ();
  mem_arbiter_if #(.ADDR_WIDTH(AW)) bus2 ();
  mem_arbiter_if #(.ADDR_WIDTH(AW)) bus3 ();

  mem_arbiter #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (.clk(clk), .rst_n(rst_n0), .bus(bus0.slave), .dbg(dbg0));
  mem_arbiter #(.ADDR_WIDTH(AW), .WAIT_STATES(2)) dut2 (.clk(clk), .rst_n(rst_n2), .bus(bus2.slave), .dbg(dbg2));
  mem_arbiter #(.ADDR_WIDTH(AW), .WAIT_STATES(3)) dut3 (.clk(clk), .rst_n(rst_n3), .bus(bus3.slave), .dbg(dbg3));

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory models ----------------
  always @(posedge clk) begin
    if (bus0.mem_en_o) begin
      for (int b = 0; b < 4; b++)
        if (bus0.mem_we_o && bus0.mem_be_o[b]) mem0[bus0.mem_addr_o[7:0]][b*8 +: 8] <= bus0.mem_wdata_o[b*8 +: 8];
      bus0.mem_rdata_i <= mem0[bus0.mem_addr_o[7:0]];
    end
    if (bus2.mem_en_o) begin
      for (int b = 0; b < 4; b++)
        if (bus2.mem_we_o && bus2.mem_be_o[b]) mem2[bus2.mem_addr_o[7:0]][b*8 +: 8] <= bus2.mem_wdata_o[b*8 +: 8];
      bus2.mem_rdata_i <= mem2[bus2.mem_addr_o[7:0]];
    end
    if (bus3.mem_en_o) begin
      for (int b = 0; b < 4; b++)
        if (bus3.mem_we_o && bus3.mem_be_o[b]) mem3[bus3.mem_addr_o[7:0]][b*8 +: 8] <= bus3.mem_wdata_o[b*8 +: 8];
      bus3.mem_rdata_i <= mem3[bus3.mem_addr_o[7:0]];
    end
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int gcount, ecount, t_tag;
    t_tag = 0;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 32'h0; mem2[i] = 32'h0; mem3[i] = 32'h0;
    end
    mem0[8'h10] = 32'hDEADBEEF;
    mem0[8'h21] = 32'hCAFEF00D;
    mem2[8'h20] = 32'hAAAAAAAA;
    mem2[8'h22] = 32'h22222222;
    mem2[8'h30] = 32'h30303030;
    mem2[8'h31] = 32'h31313131;
    mem3[8'h05] = 32'h05050505;

    rst_n0 = 1'b0; rst_n2 = 1'b0; rst_n3 = 1'b0;
    // bus0 requests during reset: nothing may be granted
    bus0.instr_req_i = 1'b1; bus0.instr_addr_i = 24'h10;
    bus0.data_req_i = 1'b1; bus0.data_addr_i = 24'h21; bus0.data_we_i = 1'b1;
    bus0.data_be_i = 4'hF; bus0.data_wdata_i = 32'h0;
    bus2.instr_req_i = 1'b0; bus2.instr_addr_i = '0;
    bus2.data_req_i = 1'b0; bus2.data_addr_i = '0; bus2.data_we_i = 1'b0;
    bus2.data_be_i = 4'h0; bus2.data_wdata_i = 32'h0;
    bus3.instr_req_i = 1'b0; bus3.instr_addr_i = '0;
    bus3.data_req_i = 1'b0; bus3.data_addr_i = '0; bus3.data_we_i = 1'b0;
    bus3.data_be_i = 4'h0; bus3.data_wdata_i = 32'h0;

    cyc(); cyc(); #1;
    check("rst_instr_gnt", bus0.instr_gnt_o, 1'b0);
    check("rst_data_gnt", bus0.data_gnt_o, 1'b0);
    check("rst_instr_rvalid", bus0.instr_rvalid_o, 1'b0);
    check("rst_data_rvalid", bus0.data_rvalid_o, 1'b0);
    check("rst_mem_en", bus0.mem_en_o, 1'b0);
    check("rst_mem_we", bus0.mem_we_o, 1'b0);
    check("rst_state", dbg0.state, ST_IDLE);

    cyc();
    rst_n0 = 1'b1; rst_n2 = 1'b1; rst_n3 = 1'b1;
    bus0.instr_req_i = 1'b0; bus0.data_req_i = 1'b0; bus0.data_we_i = 1'b0;

    // ---- WS=0: single instruction read ----
    cyc();
    bus0.instr_req_i = 1'b1; bus0.instr_addr_i = 24'h000010;
    #1;
    check("t1_instr_gnt", bus0.instr_gnt_o, 1'b1);
    check("t1_mem_en", bus0.mem_en_o, 1'b1);
    check("t1_mem_addr", bus0.mem_addr_o, 24'h000010);
    check("t1_data_rvalid_g", bus0.data_rvalid_o, 1'b0);
    check("t1_instr_rvalid_g", bus0.instr_rvalid_o, 1'b0);
    cyc();
    bus0.instr_req_i = 1'b0;
    #1;
    check("t1_instr_rvalid", bus0.instr_rvalid_o, 1'b1);
    check("t1_instr_rdata", bus0.instr_rdata_o, 32'hDEADBEEF);
    check("t1_data_rvalid_r", bus0.data_rvalid_o, 1'b0);
    check("t1_instr_gnt_off", bus0.instr_gnt_o, 1'b0);
    cyc(); #1;
    check("t1_instr_rvalid_once", bus0.instr_rvalid_o, 1'b0);

    // ---- WS=0: both ports continuously from reset -> D,I,D,I,... ----
    cyc(); rst_n0 = 1'b0;
    cyc(); rst_n0 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      bus0.instr_req_i = 1'b1; bus0.instr_addr_i = 24'h10;
      bus0.data_req_i = 1'b1; bus0.data_addr_i = 24'h21; bus0.data_we_i = 1'b0;
      #1;
      check($sformatf("rr_dgnt_%0d", k), bus0.data_gnt_o, (k % 2) == 0);
      check($sformatf("rr_ignt_%0d", k), bus0.instr_gnt_o, (k % 2) == 1);
      if (k > 0) begin
        check($sformatf("rr_drv_%0d", k), bus0.data_rvalid_o, ((k - 1) % 2) == 0);
        check($sformatf("rr_irv_%0d", k), bus0.instr_rvalid_o, ((k - 1) % 2) == 1);
        check($sformatf("rr_rdata_%0d", k), bus0.data_rdata_o,
              (((k - 1) % 2) == 0) ? 32'hCAFEF00D : 32'hDEADBEEF);
      end
    end
    cyc();
    bus0.instr_req_i = 1'b0; bus0.data_req_i = 1'b0;
    #1;
    check("rr_last_irv", bus0.instr_rvalid_o, 1'b1);
    check("rr_last_drv", bus0.data_rvalid_o, 1'b0);
    check("rr_last_rdata", bus0.instr_rdata_o, 32'hDEADBEEF);

    // ---- WS=2: data write at t with instruction pending ----
    cyc();
    bus2.data_req_i = 1'b1; bus2.data_addr_i = 24'h000020; bus2.data_we_i = 1'b1;
    bus2.data_be_i = 4'b0011; bus2.data_wdata_i = 32'h00001234;
    bus2.instr_req_i = 1'b1; bus2.instr_addr_i = 24'h000030;
    #1;
    check("ws2_t_dgnt", bus2.data_gnt_o, 1'b1);
    check("ws2_t_ignt", bus2.instr_gnt_o, 1'b0);
    check("ws2_t_mem_en", bus2.mem_en_o, 1'b1);
    check("ws2_t_mem_we", bus2.mem_we_o, 1'b1);
    check("ws2_t_mem_be", bus2.mem_be_o, 4'b0011);
    check("ws2_t_mem_addr", bus2.mem_addr_o, 24'h000020);
    check("ws2_t_mem_wdata", bus2.mem_wdata_o, 32'h00001234);
    for (int k = 1; k <= 2; k++) begin
      cyc();
      bus2.data_req_i = 1'b0; bus2.data_we_i = 1'b0; bus2.data_be_i = 4'h0;
      #1;
      check($sformatf("ws2_t%0d_ignt", k), bus2.instr_gnt_o, 1'b0);
      check($sformatf("ws2_t%0d_dgnt", k), bus2.data_gnt_o, 1'b0);
      check($sformatf("ws2_t%0d_mem_en", k), bus2.mem_en_o, 1'b0);
      check($sformatf("ws2_t%0d_drv", k), bus2.data_rvalid_o, 1'b0);
      check($sformatf("ws2_t%0d_state", k), dbg2.state, ST_WAIT);
    end
    check("ws2_mem_written", mem2[8'h20], 32'hAAAA1234);
    // t+3: response to the write and the fetch grant together; the data
    // port shows a write that must not leak into the fetch
    cyc();
    bus2.data_we_i = 1'b1; bus2.data_wdata_i = 32'hFFFFFFFF; bus2.data_be_i = 4'b0101;
    #1;
    check("ws2_t3_drv", bus2.data_rvalid_o, 1'b1);
    check("ws2_t3_ignt", bus2.instr_gnt_o, 1'b1);
    check("ws2_t3_irv", bus2.instr_rvalid_o, 1'b0);
    check("ws2_t3_mem_addr", bus2.mem_addr_o, 24'h000030);
    check("ifetch_mem_we", bus2.mem_we_o, 1'b0);
    check("ifetch_mem_be", bus2.mem_be_o, 4'b1111);
    check("ifetch_mem_wdata", bus2.mem_wdata_o, 32'h0);
    for (int k = 4; k <= 5; k++) begin
      cyc();
      bus2.instr_req_i = 1'b0; bus2.data_we_i = 1'b0;
      bus2.data_wdata_i = 32'h0; bus2.data_be_i = 4'h0;
      #1;
      check($sformatf("ws2_t%0d_irv", k), bus2.instr_rvalid_o, 1'b0);
      check($sformatf("ws2_t%0d_mem_en", k), bus2.mem_en_o, 1'b0);
    end
    // t+6: fetch response, and a new fetch grant in the same cycle
    cyc();
    bus2.instr_req_i = 1'b1; bus2.instr_addr_i = 24'h000031;
    #1;
    check("ws2_t6_irv", bus2.instr_rvalid_o, 1'b1);
    check("ws2_t6_irdata", bus2.instr_rdata_o, 32'h30303030);
    check("ws2_t6_ignt", bus2.instr_gnt_o, 1'b1);
    check("ws2_t6_drv", bus2.data_rvalid_o, 1'b0);

    // ---- WS=2: data_req held through ST_WAIT, granted once ----
    gcount = 0; ecount = 0;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      bus2.instr_req_i = 1'b0;
      bus2.data_req_i = (gcount == 0); bus2.data_addr_i = 24'h000022; bus2.data_we_i = 1'b0;
      #1;
      if (bus2.data_gnt_o) gcount++;
      if (bus2.mem_en_o) ecount++;
      check($sformatf("hold_dgnt_%0d", k), bus2.data_gnt_o, k == 3);
      check($sformatf("hold_irv_%0d", k), bus2.instr_rvalid_o, k == 3);
      check($sformatf("hold_drv_%0d", k), bus2.data_rvalid_o, k == 6);
      if (k == 3) check("hold_irdata", bus2.instr_rdata_o, 32'h31313131);
      if (k == 6) check("hold_drdata", bus2.data_rdata_o, 32'h22222222);
    end
    check("hold_grant_count", gcount, 1);
    check("hold_mem_en_count", ecount, 1);

    // ---- WS=3: reset during ST_WAIT drops the response ----
    cyc();
    bus3.data_req_i = 1'b1; bus3.data_addr_i = 24'h000005; bus3.data_we_i = 1'b0;
    #1;
    check("ws3_dgnt", bus3.data_gnt_o, 1'b1);
    cyc();
    bus3.data_req_i = 1'b0;
    #1;
    check("ws3_state_wait", dbg3.state, ST_WAIT);
    cyc();
    rst_n3 = 1'b0; bus3.instr_req_i = 1'b1; bus3.data_req_i = 1'b1;
    #1;
    check("ws3_rst_ignt", bus3.instr_gnt_o, 1'b0);
    check("ws3_rst_dgnt", bus3.data_gnt_o, 1'b0);
    check("ws3_rst_mem_en", bus3.mem_en_o, 1'b0);
    check("ws3_rst_state", dbg3.state, ST_IDLE);
    cyc();
    rst_n3 = 1'b1; bus3.instr_req_i = 1'b0; bus3.data_req_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (bus3.data_rvalid_o || bus3.instr_rvalid_o) t_tag++;
      cyc();
    end
    check("ws3_no_rvalid", t_tag, 0);
    bus3.instr_req_i = 1'b1; bus3.instr_addr_i = 24'h000040;
    bus3.data_req_i = 1'b1; bus3.data_addr_i = 24'h000005;
    #1;
    check("ws3_tie_dgnt", bus3.data_gnt_o, 1'b1);
    check("ws3_tie_ignt", bus3.instr_gnt_o, 1'b0);
    cyc();
    bus3.instr_req_i = 1'b0; bus3.data_req_i = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
